// File: rtl/mult_div_if.sv
// Request/response bundle between the CPU control unit (master) and the
// multiply/divide unit (slave).
//
// Handshake: the master pulses start with op/a_in/b_in. The slave samples
// them only while busy is low, and a start seen while busy is dropped. A
// request finishes with a one-cycle done pulse, and hi/lo are valid in that
// same cycle. div0 pulses together with done when a divide has a zero divisor.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div0;

  modport master (
    output start, op, a_in, b_in,
    input  hi, lo, busy, done, div0
  );

  modport slave (
    input  start, op, a_in, b_in,
    output hi, lo, busy, done, div0
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit. It works on operand magnitudes
// for 32 iterations: shift-add for MULT and restoring division for DIV.
// One fix-up cycle then applies the result signs and loads hi/lo.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               zero_q, zero_d;   // divide-by-zero request pending in FIX
  logic               neg_q, neg_d;     // product / quotient sign
  logic               rneg_q, rneg_d;   // remainder sign (dividend sign)
  logic [WIDTH-1:0]   mag_q, mag_d;     // |a| for MULT, |b| for DIV
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;

  // 0x80000000 maps to itself, which is 2^31 when read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? -v : v;
  endfunction

  // One shift-add step. The upper half holds the partial product and the
  // lower half shifts out the multiplier bits.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-division step. The upper half is the partial remainder
  // and the lower half shifts the dividend out and the quotient in.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ge};

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      mag_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  // Next-state, iteration and sign-fixup logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          neg_d  = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
          rneg_d = bus.a_in[WIDTH-1];
          cnt_d  = '0;
          if (bus.op && (bus.b_in == '0)) begin
            // A zero divisor skips the iterations and reports in FIX next cycle.
            zero_d  = 1'b1;
            state_d = S_FIX;
          end else begin
            zero_d  = 1'b0;
            mag_d   = bus.op ? mag(bus.b_in) : mag(bus.a_in);
            acc_d   = {{WIDTH{1'b0}}, (bus.op ? mag(bus.a_in) : mag(bus.b_in))};
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = op_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (zero_q) begin
          div0_d = 1'b1;
        end else if (op_q) begin
          lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.div0    = div0_q;
  assign dbg_state_o = state_q;

endmodule
